// File: rtl/wgt_stream_writer.sv
// Weight stream writer: packs IN_BYTES-wide DMA beats into TN-byte rows and writes
// them into the ping-pong weight SRAM, handing each filled bank to the consumer.
module wgt_stream_writer #(
  parameter int TN         = 14,
  parameter int ADDR_WIDTH = 7,
  parameter int IN_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_BYTES*8-1:0] s_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [TN*8-1:0]       wdata,
  output logic                  bank_sel_wr,
  output logic [1:0]            bank_full,
  input  logic [1:0]            bank_release,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  // state    | meaning
  // S_IDLE   | waiting for cfg_start
  // S_WAIT   | tile accepted, target bank still owned by the consumer
  // S_FILL   | accepting beats and emitting rows
  // S_FINISH | last row written, hand the bank to the consumer

  localparam int ACC_BYTES = TN + IN_BYTES - 1;
  localparam int ACC_W     = ACC_BYTES * 8;
  localparam int CW        = $clog2(ACC_BYTES + 1);
  localparam int BR_W      = $clog2((2 ** ADDR_WIDTH) * TN + 1);

  localparam logic [CW-1:0]       TN_C    = CW'(TN);
  localparam logic [CW-1:0]       IN_C    = CW'(IN_BYTES);
  localparam logic [CW-1:0]       CAP_C   = CW'(ACC_BYTES);
  localparam logic [BR_W-1:0]     IN_BR   = BR_W'(IN_BYTES);
  localparam logic [ADDR_WIDTH:0] DEPTH_R = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_R   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]            state;
  logic                  wr_bank;
  logic [ADDR_WIDTH:0]   rows;
  logic [ADDR_WIDTH:0]   row_cnt;
  logic [BR_W-1:0]       bytes_rem;
  logic [CW-1:0]         acc_cnt;
  logic [ACC_W-1:0]      acc;

  logic                  row_rdy;
  logic                  accept;
  logic                  cfg_legal;
  logic                  last_row;
  logic [CW-1:0]         take_n;
  logic [IN_BYTES*8-1:0] beat_masked;
  logic [ACC_W-1:0]      acc_ins;
  logic [1:0]            full_set;

  // Bytes past the end of the tile are zeroed so they never reach the accumulator.
  always_comb begin
    row_rdy     = (acc_cnt >= TN_C);
    take_n      = (bytes_rem < IN_BR) ? CW'(bytes_rem) : IN_C;
    beat_masked = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (CW'(i) < take_n) beat_masked[8*i +: 8] = s_data[8*i +: 8];
    end
    acc_ins   = ACC_W'(beat_masked) << {acc_cnt, 3'b000};
    cfg_legal = (cfg_rows != '0) && (cfg_rows <= DEPTH_R);
    last_row  = (row_cnt == rows - ONE_R);
    full_set  = (state == S_FINISH) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  end

  assign s_ready = (state == S_FILL) && !row_rdy && (bytes_rem != '0);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_bank     <= 1'b0;
      rows        <= '0;
      row_cnt     <= '0;
      bytes_rem   <= '0;
      acc_cnt     <= '0;
      acc         <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      bank_sel_wr <= 1'b0;
      bank_full   <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      we        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      // a set in the same cycle as a release of that bank wins
      bank_full <= (bank_full & ~bank_release) | full_set;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_legal) begin
              rows      <= cfg_rows;
              bytes_rem <= BR_W'(cfg_rows) * BR_W'(TN);
              row_cnt   <= '0;
              acc_cnt   <= '0;
              acc       <= '0;
              busy      <= 1'b1;
              state     <= S_WAIT;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!bank_full[wr_bank]) state <= S_FILL;
        end
        S_FILL: begin
          if (row_rdy) begin
            we          <= 1'b1;
            waddr       <= row_cnt[ADDR_WIDTH-1:0];
            bank_sel_wr <= wr_bank;
            wdata       <= acc[TN*8-1:0];
            acc         <= acc >> (TN * 8);
            acc_cnt     <= acc_cnt - TN_C;
            row_cnt     <= row_cnt + ONE_R;
            if (last_row) state <= S_FINISH;
          end else if (accept) begin
            acc       <= acc | acc_ins;
            acc_cnt   <= acc_cnt + take_n;
            bytes_rem <= bytes_rem - BR_W'(take_n);
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          wr_bank <= ~wr_bank;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_acc_cap: assert property (@(posedge clk) disable iff (rst) acc_cnt <= CAP_C);

endmodule

// File: tb/tb_wgt_stream_writer.sv
// Directed bench for wgt_stream_writer: packing, bank ping-pong, illegal sizes,
// gapped streams and mid-tile reset, with hand-derived expected rows.
module tb_wgt_stream_writer;
  localparam int TN = 14;
  localparam int AW = 7;
  localparam int IB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [AW:0]     cfg_rows;
  logic            s_valid;
  logic            s_ready;
  logic [IB*8-1:0] s_data;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [TN*8-1:0] wdata;
  logic            bank_sel_wr;
  logic [1:0]      bank_full;
  logic [1:0]      bank_release;
  logic            busy;
  logic            done;
  logic            err;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, b2b = 0;
  logic prev_we = 1'b0;
  logic [AW-1:0]   wq_addr[$];
  logic [TN*8-1:0] wq_data[$];
  logic            wq_bank[$];
  int              wq_cyc[$];
  int              beat_cyc[$];

  wgt_stream_writer #(.TN(TN), .ADDR_WIDTH(AW), .IN_BYTES(IB)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_rows(cfg_rows),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .we(we), .waddr(waddr), .wdata(wdata), .bank_sel_wr(bank_sel_wr),
    .bank_full(bank_full), .bank_release(bank_release),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(waddr);
      wq_data.push_back(wdata);
      wq_bank.push_back(bank_sel_wr);
      wq_cyc.push_back(cyc);
    end
    if (we && prev_we) b2b++;
    prev_we = we;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int r);
    cfg_rows  = (AW+1)'(r);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic release_banks(input logic [1:0] m);
    bank_release = m;
    tick();
    bank_release = 2'b00;
  endtask

  task automatic clear_log();
    wq_addr.delete(); wq_data.delete(); wq_bank.delete(); wq_cyc.delete(); beat_cyc.delete();
  endtask

  function automatic logic [TN*8-1:0] exp_row(input int first);
    logic [TN*8-1:0] r;
    for (int i = 0; i < TN; i++) r[8*i +: 8] = 8'((first + i) % 256);
    return r;
  endfunction

  // Byte k of the stream carries value k mod 256.
  task automatic send_beats(input int first, input int nbeats, input int gap_pct, output int n_acc);
    bit got;
    n_acc = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      s_valid = 1'b1;
      for (int k = 0; k < IB; k++) s_data[8*k +: 8] = 8'((first + IB*b + k) % 256);
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        if (s_ready) begin
          got = 1'b1;
          beat_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
      end
      if (!got) begin
        check_val("beat_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      n_acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic count_ready(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (s_ready) c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt > base) return;
      tick();
    end
    check_val(tag, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c, base, ebase;
    rst = 1'b1; cfg_start = 1'b0; cfg_rows = '0; s_valid = 1'b0; s_data = '0; bank_release = 2'b00;
    repeat (3) tick();
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_we", we, 0);
    check_val("rst_waddr", waddr, 0);
    check_val("rst_wdata", wdata, 0);
    check_val("rst_bank_sel", bank_sel_wr, 0);
    check_val("rst_bank_full", bank_full, 0);
    check_val("rst_busy_done_err", {busy, done, err}, 0);
    rst = 1'b0;
    tick();

    // Test 1: two rows, seven beats
    clear_log(); base = done_cnt; ebase = err_cnt;
    start_tile(2);
    send_beats(0, 7, 0, n);
    @(negedge clk);
    check_val("t1_sready_after_last", s_ready, 0);
    @(posedge clk); #1;
    wait_done(base, "t1_done_timeout");
    check_val("t1_n_writes", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check_val("t1_addr0", wq_addr[0], 0);
      check_val("t1_data0", wq_data[0], exp_row(0));
      check_val("t1_bank0", wq_bank[0], 0);
      check_val("t1_addr1", wq_addr[1], 1);
      check_val("t1_data1", wq_data[1], exp_row(14));
      check_val("t1_bank1", wq_bank[1], 0);
      if (beat_cyc.size() >= 4) check_val("t1_latency", wq_cyc[0] - beat_cyc[3], 2);
    end
    check_val("t1_bank_full", bank_full, 2'b01);
    tick();
    check_val("t1_done_pulse", done, 0);
    check_val("t1_idle_busy", busy, 0);
    check_val("t1_no_err", err_cnt - ebase, 0);

    // Test 2: one row, excess bytes in the last beat dropped, fifth beat held
    clear_log(); base = done_cnt;
    start_tile(1);
    send_beats(0, 4, 0, n);
    check_val("t2_accepted", n, 4);
    s_valid = 1'b1;
    s_data = 32'h13121110;
    count_ready(8, c);
    s_valid = 1'b0;
    check_val("t2_fifth_held", c, 0);
    wait_done(base, "t2_done_timeout");
    check_val("t2_n_writes", wq_addr.size(), 1);
    if (wq_addr.size() == 1) begin
      check_val("t2_data", wq_data[0], exp_row(0));
      check_val("t2_bank", wq_bank[0], 1);
    end
    check_val("t2_bank_full", bank_full, 2'b11);
    release_banks(2'b11);
    check_val("t2_released", bank_full, 2'b00);

    // Test 3: three tiles, third waits for bank 0
    clear_log();
    for (int t = 0; t < 2; t++) begin
      base = done_cnt;
      start_tile(1);
      send_beats(0, 4, 0, n);
      wait_done(base, "t3_done_timeout");
    end
    check_val("t3_full_after_two", bank_full, 2'b11);
    base = done_cnt;
    start_tile(1);
    s_valid = 1'b1;
    s_data = 32'h03020100;
    count_ready(10, c);
    s_valid = 1'b0;
    check_val("t3_wait_sready", c, 0);
    check_val("t3_wait_busy", busy, 1);
    check_val("t3_wait_no_write", wq_addr.size(), 2);
    release_banks(2'b01);
    send_beats(0, 4, 0, n);
    wait_done(base, "t3_done3_timeout");
    check_val("t3_n_writes", wq_addr.size(), 3);
    if (wq_addr.size() == 3) begin
      check_val("t3_bank_t1", wq_bank[0], 0);
      check_val("t3_bank_t2", wq_bank[1], 1);
      check_val("t3_bank_t3", wq_bank[2], 0);
      check_val("t3_data_t3", wq_data[2], exp_row(0));
    end
    check_val("t3_bank_full", bank_full, 2'b11);
    release_banks(2'b11);

    // Test 4: full-depth tile, gap-free then with random gaps
    for (int g = 0; g < 2; g++) begin
      clear_log(); base = done_cnt;
      start_tile(128);
      send_beats(0, 448, (g == 0) ? 0 : 30, n);
      wait_done(base, "t4_done_timeout");
      check_val($sformatf("t4_g%0d_n_writes", g), wq_addr.size(), 128);
      for (int r = 0; r < 128 && r < wq_addr.size(); r++) begin
        check_val($sformatf("t4_g%0d_addr_%0d", g, r), wq_addr[r], r);
        check_val($sformatf("t4_g%0d_data_%0d", g, r), wq_data[r], exp_row(r * TN));
      end
      if (wq_addr.size() == 128) begin
        check_val($sformatf("t4_g%0d_bank_first", g), wq_bank[0], (g == 0) ? 1 : 0);
        check_val($sformatf("t4_g%0d_bank_last", g), wq_bank[127], (g == 0) ? 1 : 0);
      end
      if (g == 0) begin
        check_val("t4_g0_full", bank_full, 2'b10);
        release_banks(2'b10);
      end
    end
    check_val("t4_g1_full", bank_full, 2'b01);
    check_val("no_back_to_back_we", b2b, 0);

    // Test 5: illegal row counts
    clear_log();
    for (int k = 0; k < 2; k++) begin
      base = done_cnt; ebase = err_cnt;
      start_tile((k == 0) ? 0 : 129);
      check_val($sformatf("t5_%0d_done", k), done, 1);
      check_val($sformatf("t5_%0d_err", k), err, 1);
      check_val($sformatf("t5_%0d_busy", k), busy, 0);
      tick();
      check_val($sformatf("t5_%0d_pulse_end", k), {done, err}, 2'b00);
      repeat (3) tick();
      check_val($sformatf("t5_%0d_err_once", k), err_cnt - ebase, 1);
    end
    check_val("t5_no_we", wq_addr.size(), 0);
    check_val("t5_bank_full", bank_full, 2'b01);

    // Test 6: reset after three rows of a ten-row tile
    clear_log();
    start_tile(10);
    send_beats(0, 12, 0, n);
    for (int i = 0; i < 20 && wq_addr.size() < 3; i++) tick();
    check_val("t6_three_writes", wq_addr.size(), 3);
    check_val("t6_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check_val("t6_s_ready", s_ready, 0);
    check_val("t6_we", we, 0);
    check_val("t6_waddr", waddr, 0);
    check_val("t6_wdata", wdata, 0);
    check_val("t6_bank_sel", bank_sel_wr, 0);
    check_val("t6_bank_full", bank_full, 2'b00);
    check_val("t6_busy_done_err", {busy, done, err}, 0);
    rst = 1'b0;
    tick();
    clear_log(); base = done_cnt;
    start_tile(1);
    send_beats(0, 4, 0, n);
    wait_done(base, "t6_done_timeout");
    check_val("t6_fresh_n_writes", wq_addr.size(), 1);
    if (wq_addr.size() == 1) begin
      check_val("t6_fresh_addr", wq_addr[0], 0);
      check_val("t6_fresh_bank", wq_bank[0], 0);
      check_val("t6_fresh_data", wq_data[0], exp_row(0));
    end
    check_val("t6_fresh_full", bank_full, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wgt_stream_writer.md
Name: wgt_stream_writer

Overview:
- Producer-side writer for the double-buffered weight SRAM. It accepts a narrow byte stream from the weight DMA over a valid/ready handshake.
- Packs the stream into TN-byte rows and issues the buffer write port (we/waddr/wdata/bank_sel_wr).
- Manages ping-pong bank ownership against the systolic-array consumer with per-bank full flags and release pulses.

Parameters:
- TN, 14, weight lanes per row; row width TN*8 bits.
- ADDR_WIDTH, 7, row address width; DEPTH = 2**ADDR_WIDTH rows per bank.
- IN_BYTES, 4, bytes per input stream beat; 1 <= IN_BYTES <= TN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse to start a tile load; ignored unless in IDLE.
- cfg_rows  in  ADDR_WIDTH+1  rows in the tile; sampled on cfg_start.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat accepted when s_valid & s_ready.
- s_data  in  IN_BYTES*8  beat payload; bits [7:0] are the earliest byte.
- we  out  1  buffer write enable, one cycle per row.
- waddr  out  ADDR_WIDTH  buffer row address.
- wdata  out  TN*8  row data; bits [8i+7:8i] = lane i = i-th byte of the row.
- bank_sel_wr  out  1  target bank for the current write.
- bank_full  out  2  bit b set = bank b holds a complete tile owned by the consumer.
- bank_release  in  2  consumer pulse; bit b clears bank_full[b].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a tile completes or is rejected.
- err  out  1  one-cycle pulse alongside done for a rejected cfg_rows.

Behaviour:
- Reset values:
  - Outputs: s_ready=0, we=0, waddr=0, wdata=0, bank_sel_wr=0, bank_full=2'b00, busy=0, done=0, err=0.
  - Internal: wr_bank=0, byte accumulator empty (acc_cnt=0), state IDLE.
- All outputs are registered except s_ready, which is combinational from state and counters.
- Reset mid-operation abandons the tile; rows already written are left in the SRAM but are not flagged full.
- States: IDLE, WAIT_BANK, FILL, FINISH.
- IDLE:
  - On cfg_start with cfg_rows==0 or cfg_rows>DEPTH: done=1 and err=1 next cycle, stay IDLE, no writes.
  - On cfg_start with a legal cfg_rows: latch rows, bytes_rem = rows*TN, row_cnt=0, acc_cnt=0, then go to WAIT_BANK.
- WAIT_BANK: when bank_full[wr_bank]==0, go to FILL. s_ready stays 0 while waiting.
- FILL:
  - s_ready = (acc_cnt < TN) && (bytes_rem > 0).
  - On an accepted beat:
    - Append min(IN_BYTES, bytes_rem) bytes to the accumulator in byte order.
    - Decrement bytes_rem by that amount.
    - Excess bytes in the final beat are discarded.
  - When acc_cnt >= TN at a clock edge, register a write:
    - we=1, waddr=row_cnt, bank_sel_wr=wr_bank, wdata = lowest TN accumulator bytes.
    - Shift the accumulator down by TN bytes and increment row_cnt.
  - No beat is accepted in a cycle where acc_cnt >= TN.
  - Latency: a beat accepted in cycle t that brings acc_cnt to >= TN produces we=1 in cycle t+2.
  - After the write for row rows-1 is registered, go to FINISH.
- FINISH: on the edge after the final we cycle:
  - bank_full[wr_bank] <= 1, done <= 1 (one cycle), toggle wr_bank, go to IDLE.
  - The consumer may issue reads from the cycle in which bank_full rises.
- bank_full:
  - bank_release[b] clears bit b in any state, including reset-free operation during FILL.
  - Release of an already-clear bit is a no-op.
  - A set and a release of the same bit in the same cycle: set wins.
- Accumulator capacity is TN+IN_BYTES-1 bytes; overflow is impossible by construction. An assertion checks acc_cnt <= TN+IN_BYTES-1.
- we is never high for two consecutive cycles when IN_BYTES < TN.
- waddr never reaches rows.
- Throughput: one row per ceil(TN/IN_BYTES)+1 cycles or better under continuous s_valid.

Test Plan (TN=14, ADDR_WIDTH=7, IN_BYTES=4):
1. cfg_rows=2, 7 beats carrying bytes 0x00..0x1B:
   - we at waddr 0 with lanes 0..13 = 0x00..0x0D, then waddr 1 with lanes = 0x0E..0x1B, both on bank 0.
   - Then done pulse, bank_full=2'b01, s_ready=0 after beat 7.
2. cfg_rows=1, bytes 0x00..0x0F offered:
   - Exactly 4 beats accepted, bytes 0x0E/0x0F discarded.
   - One write, lanes=0x00..0x0D; a 5th beat is held (s_ready=0).
3. Three back-to-back legal tiles with no release:
   - Tile 1 goes to bank 0, tile 2 to bank 1.
   - Tile 3 sits in WAIT_BANK with s_ready=0 until bank_release=2'b01, then writes bank 0. Final bank_full=2'b11.
4. cfg_rows=128 with random s_valid gaps: 128 writes, waddr 0..127 in order, data identical to the gap-free run.
5. cfg_rows=0 and then cfg_rows=129: each gives done=1 and err=1 for one cycle, no we, bank_full unchanged.
6. rst asserted mid-FILL after 3 writes:
   - Next cycle all outputs are at reset values, bank_full=0.
   - A fresh cfg_rows=1 load writes waddr 0 on bank 0.
